nfu2_acc_ctrl: RTL and testbench

Sequencing controller for the NFU-2 accumulation pipe (adder tree plus partial-sum register).
For each of N_out output tiles it:
- primes the partial-sum register, either from NBout or with zero;
- admits N_in product tiles from NFU-1, one per handshake;
- waits out the adder pipeline;
- writes the finished Tn-wide sum back to NBout.

It sits between the layer sequencer (start/done), the NFU-1 output, the NFU-2 datapath control pins and the NBout read/write ports.

---
 rtl/nfu_ctrl_pkg.sv | 20 ++
 rtl/nfu2_acc_ctrl_if.sv | 42 ++++
 rtl/tile_counter.sv | 30 +++
 rtl/nfu2_acc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nfu2_acc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nfu_ctrl_pkg.sv
// Shared definitions for the NFU pipe controllers.
// Holds the controller state encoding and the default sizing
// parameters reused by the NFU-1/NFU-2/NFU-3 sequencers.
package nfu_ctrl_pkg;

    localparam int unsigned CNT_W_DEF        = 8;
    localparam int unsigned PIPE_LAT_DEF     = 1;
    localparam int unsigned NBOUT_RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_LOAD,
        ST_ACCUM,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/nfu2_acc_ctrl_if.sv
// Signal bundle between the NFU-2 accumulation controller and its environment.
// master: layer sequencer / NFU-1 / datapath / NBout side (drives i_*)
// slave : the controller (drives o_*)
//   i_start, i_num_in_tiles, i_num_out_tiles, i_acc_init : pass configuration
//   i_nfu1_valid / o_nfu1_ready, o_nfu1_gate             : NFU-1 product handshake
//   o_load_partial_sum, o_zero_partial                   : NFU-2 datapath control
//   o_nbout_rd_*, o_nbout_wr_*                           : NBout ports
//   o_busy, o_done                                       : pass status
interface nfu2_acc_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             i_start;
    logic [CNT_W-1:0] i_num_in_tiles;
    logic [CNT_W-1:0] i_num_out_tiles;
    logic             i_acc_init;
    logic             i_nfu1_valid;
    logic             o_nfu1_ready;
    logic             o_nfu1_gate;
    logic             o_load_partial_sum;
    logic             o_zero_partial;
    logic             o_nbout_rd_en;
    logic [CNT_W-1:0] o_nbout_rd_addr;
    logic             o_nbout_wr_en;
    logic [CNT_W-1:0] o_nbout_wr_addr;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_num_in_tiles, i_num_out_tiles, i_acc_init, i_nfu1_valid,
        input  o_nfu1_ready, o_nfu1_gate, o_load_partial_sum, o_zero_partial,
        input  o_nbout_rd_en, o_nbout_rd_addr, o_nbout_wr_en, o_nbout_wr_addr,
        input  o_busy, o_done
    );

    modport slave (
        input  i_start, i_num_in_tiles, i_num_out_tiles, i_acc_init, i_nfu1_valid,
        output o_nfu1_ready, o_nfu1_gate, o_load_partial_sum, o_zero_partial,
        output o_nbout_rd_en, o_nbout_rd_addr, o_nbout_wr_en, o_nbout_wr_addr,
        output o_busy, o_done
    );

endinterface

// File: rtl/tile_counter.sv
// Loadable up-counter with terminal-count flag.
// Ports: clk, rst (sync, active high), clr (return to zero), inc (count up),
//        limit (tile count N), count (registered value),
//        last_c (combinational: count is the final tile, N-1).
module tile_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last_c
);

    // Clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign last_c = (count == limit - W'(1));

endmodule

// File: rtl/nfu2_acc_ctrl.sv
// NFU-2 accumulation sequencer: per output tile, primes the partial-sum
// register (NBout data or zero), admits N_in NFU-1 products, drains the
// adder pipe and writes the Tn-wide sum back to NBout.
// Ports: clk, rst (sync, active high), bus (nfu2_acc_ctrl_if.slave).
module nfu2_acc_ctrl
    import nfu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned PIPE_LAT     = PIPE_LAT_DEF,
    parameter int unsigned NBOUT_RD_LAT = NBOUT_RD_LAT_DEF
) (
    input logic            clk,
    input logic            rst,
    nfu2_acc_ctrl_if.slave bus
);

    localparam int unsigned WAIT_MAX = (PIPE_LAT > NBOUT_RD_LAT) ? PIPE_LAT : NBOUT_RD_LAT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1) + 1;
    localparam logic [WAIT_W-1:0] RD_WAIT_LAST = WAIT_W'(NBOUT_RD_LAT - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST   = WAIT_W'(PIPE_LAT);

    ctrl_state_e       state_q;
    ctrl_state_e       state_nxt;
    logic [CNT_W-1:0]  num_in_q;
    logic [CNT_W-1:0]  num_out_q;
    logic              acc_init_q;
    logic [WAIT_W-1:0] wait_q;

    logic              cfg_load_c;
    logic              in_clr_c;
    logic              in_inc_c;
    logic              out_clr_c;
    logic              out_inc_c;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              in_last_c;
    logic              out_last_c;

    tile_counter #(.W(CNT_W)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (in_clr_c),
        .inc    (in_inc_c),
        .limit  (num_in_q),
        .count  (in_cnt),
        .last_c (in_last_c)
    );

    tile_counter #(.W(CNT_W)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (out_clr_c),
        .inc    (out_inc_c),
        .limit  (num_out_q),
        .count  (out_cnt),
        .last_c (out_last_c)
    );

    // State, dwell timer for PRIME/DRAIN, and configuration held for the pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            num_in_q   <= '0;
            num_out_q  <= '0;
            acc_init_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_nxt != state_q) begin
                wait_q <= '0;
            end else if (state_q == ST_PRIME || state_q == ST_DRAIN) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (cfg_load_c) begin
                num_in_q   <= bus.i_num_in_tiles;
                num_out_q  <= bus.i_num_out_tiles;
                acc_init_q <= bus.i_acc_init;
            end
        end
    end

    // Next-state and datapath/NBout control decode.
    always_comb begin
        state_nxt              = state_q;
        cfg_load_c             = 1'b0;
        in_clr_c               = 1'b0;
        in_inc_c               = 1'b0;
        out_clr_c              = 1'b0;
        out_inc_c              = 1'b0;
        bus.o_nfu1_ready       = 1'b0;
        bus.o_nfu1_gate        = 1'b0;
        bus.o_load_partial_sum = 1'b0;
        bus.o_zero_partial     = 1'b0;
        bus.o_nbout_rd_en      = 1'b0;
        bus.o_nbout_rd_addr    = '0;
        bus.o_nbout_wr_en      = 1'b0;
        bus.o_nbout_wr_addr    = '0;
        bus.o_busy             = 1'b0;
        bus.o_done             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    cfg_load_c = 1'b1;
                    in_clr_c   = 1'b1;
                    out_clr_c  = 1'b1;
                    state_nxt  = (bus.i_num_out_tiles == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                bus.o_busy = 1'b1;
                if (acc_init_q) begin
                    // Single read strobe, then hold until NBout data is valid.
                    bus.o_nbout_rd_en   = (wait_q == '0);
                    bus.o_nbout_rd_addr = out_cnt;
                    if (wait_q == RD_WAIT_LAST) begin
                        state_nxt = ST_LOAD;
                    end
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.o_busy             = 1'b1;
                bus.o_load_partial_sum = 1'b1;
                bus.o_zero_partial     = !acc_init_q;
                // in_cnt is zero here, so equality means no products to admit.
                state_nxt = (in_cnt == num_in_q) ? ST_DRAIN : ST_ACCUM;
            end
            ST_ACCUM: begin
                bus.o_busy       = 1'b1;
                bus.o_nfu1_ready = 1'b1;
                if (bus.i_nfu1_valid) begin
                    in_inc_c = 1'b1;
                    if (in_last_c) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                bus.o_busy = 1'b1;
                if (wait_q == DRAIN_LAST) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.o_busy          = 1'b1;
                bus.o_nbout_wr_en   = 1'b1;
                bus.o_nbout_wr_addr = out_cnt;
                if (out_last_c) begin
                    state_nxt = ST_DONE;
                end else begin
                    out_inc_c = 1'b1;
                    in_clr_c  = 1'b1;
                    state_nxt = ST_PRIME;
                end
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Gate is only open on an actual handshake so idle cycles add zero.
        bus.o_nfu1_gate = bus.i_nfu1_valid & bus.o_nfu1_ready;
    end

endmodule

// File: tb/tb_nfu2_acc_ctrl.sv
// Directed bench for nfu2_acc_ctrl with a small NFU-2 datapath and NBout model.
module tb_nfu2_acc_ctrl;

    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfu2_acc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    nfu2_acc_ctrl #(
        .CNT_W        (CNT_W),
        .PIPE_LAT     (1),
        .NBOUT_RD_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;

    // Environment model: NBout (1-cycle read), input register, partial-sum register.
    logic        mon_clr;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:255];
    logic [31:0] rd_data = '0;
    logic [31:0] in_reg = '0;
    logic [31:0] psum = '0;
    int unsigned pidx = 0;
    logic [31:0] prod_data;
    assign prod_data = 32'(3 + 4 * pidx);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_nbout_rd_en) rd_data <= mem[bus.o_nbout_rd_addr];
        in_reg <= bus.o_nfu1_gate ? prod_data : 32'd0;
        if (bus.o_load_partial_sum) psum <= bus.o_zero_partial ? 32'd0 : rd_data;
        else psum <= psum + in_reg;
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (bus.o_nbout_wr_en) mem[bus.o_nbout_wr_addr] <= psum;
        if (mon_clr) pidx <= 0;
        else if (bus.o_nfu1_gate) pidx <= pidx + 1;
    end

    // Event recorder, sampled mid-cycle.
    int gate_cnt, ready_cnt, busy_cnt, load_cnt, rd_cnt, wr_cnt, done_cnt, viol;
    int unsigned gate_first, gate_last, load_cyc, wr_cyc, done_cyc;
    logic        load_zero;
    logic [7:0]  rd_addr_log [4];
    logic [7:0]  wr_addr_log [4];
    logic [31:0] wr_data_log [4];

    always @(negedge clk) begin
        if (mon_clr) begin
            gate_cnt <= 0; ready_cnt <= 0; busy_cnt <= 0; load_cnt <= 0;
            rd_cnt <= 0; wr_cnt <= 0; done_cnt <= 0; viol <= 0;
            gate_first <= 0; gate_last <= 0; load_cyc <= 0; wr_cyc <= 0; done_cyc <= 0;
            load_zero <= 1'b0;
        end else begin
            if (bus.o_nfu1_gate) begin
                if (gate_cnt == 0) gate_first <= cyc;
                gate_last <= cyc;
                gate_cnt  <= gate_cnt + 1;
            end
            if (bus.o_nfu1_ready) ready_cnt <= ready_cnt + 1;
            if (bus.o_busy) busy_cnt <= busy_cnt + 1;
            if (bus.o_load_partial_sum) begin
                load_cnt  <= load_cnt + 1;
                load_zero <= bus.o_zero_partial;
                load_cyc  <= cyc;
            end
            if (bus.o_load_partial_sum && bus.o_nfu1_gate) viol <= viol + 1;
            if (bus.o_nbout_rd_en) begin
                if (rd_cnt < 4) rd_addr_log[rd_cnt] <= bus.o_nbout_rd_addr;
                rd_cnt <= rd_cnt + 1;
            end
            if (bus.o_nbout_wr_en) begin
                if (wr_cnt < 4) begin
                    wr_addr_log[wr_cnt] <= bus.o_nbout_wr_addr;
                    wr_data_log[wr_cnt] <= psum;
                end
                wr_cnt <= wr_cnt + 1;
                wr_cyc <= cyc;
            end
            if (bus.o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    logic [23:0] outs;
    assign outs = {bus.o_nfu1_ready, bus.o_nfu1_gate, bus.o_load_partial_sum, bus.o_zero_partial,
                   bus.o_nbout_rd_en, bus.o_nbout_rd_addr, bus.o_nbout_wr_en, bus.o_nbout_wr_addr,
                   bus.o_busy, bus.o_done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic run_start(input logic [7:0] nin, input logic [7:0] nout, input logic init);
        bus.i_num_in_tiles  = nin;
        bus.i_num_out_tiles = nout;
        bus.i_acc_init      = init;
        bus.i_start         = 1'b1;
        start_cyc           = cyc;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mon_clr = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        bus.i_start = 1'b0; bus.i_num_in_tiles = '0; bus.i_num_out_tiles = '0;
        bus.i_acc_init = 1'b0; bus.i_nfu1_valid = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b0;
        tick();

        // N_out=1, N_in=3, zero prime, valid held high.
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd3, 8'd1, 1'b0);
        wait_done("s1_done_seen");
        bus.i_nfu1_valid = 1'b0;
        check("s1_gate_cnt", 32'(gate_cnt), 32'd3);
        check("s1_gate_consec", gate_last - gate_first, 32'd2);
        check("s1_load_before_gate", gate_first - load_cyc, 32'd1);
        check("s1_load_cnt", 32'(load_cnt), 32'd1);
        check("s1_zero_partial", 32'(load_zero), 32'd1);
        check("s1_wr_cnt", 32'(wr_cnt), 32'd1);
        check("s1_wr_addr", 32'(wr_addr_log[0]), 32'd0);
        check("s1_wr_data", wr_data_log[0], 32'd21);
        check("s1_done_after_wr", done_cyc - wr_cyc, 32'd1);
        check("s1_latency", done_cyc - start_cyc, 32'd9);
        check("s1_done_single", 32'(done_cnt), 32'd1);
        check("s1_rd_cnt", 32'(rd_cnt), 32'd0);
        check("s1_ready_cnt", 32'(ready_cnt), 32'd3);

        // N_out=2, N_in=2, prime from NBout {5, 7}.
        preload(8'd0, 32'd5);
        preload(8'd1, 32'd7);
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd2, 8'd2, 1'b1);
        wait_done("s2_done_seen");
        bus.i_nfu1_valid = 1'b0;
        check("s2_rd_cnt", 32'(rd_cnt), 32'd2);
        check("s2_rd_addr0", 32'(rd_addr_log[0]), 32'd0);
        check("s2_rd_addr1", 32'(rd_addr_log[1]), 32'd1);
        check("s2_wr_cnt", 32'(wr_cnt), 32'd2);
        check("s2_wr_addr0", 32'(wr_addr_log[0]), 32'd0);
        check("s2_wr_data0", wr_data_log[0], 32'd15);
        check("s2_wr_addr1", 32'(wr_addr_log[1]), 32'd1);
        check("s2_wr_data1", wr_data_log[1], 32'd33);
        check("s2_busy_cycles", 32'(busy_cnt), 32'd14);
        check("s2_latency", done_cyc - start_cyc, 32'd15);
        check("s2_zero_partial", 32'(load_zero), 32'd0);

        // Stalled producer: valid 1,0,0,1,1 across ACCUM.
        clear_mon();
        run_start(8'd3, 8'd1, 1'b0);
        tick();
        tick();
        bus.i_nfu1_valid = 1'b1;
        tick();
        bus.i_nfu1_valid = 1'b0;
        tick();
        tick();
        bus.i_nfu1_valid = 1'b1;
        tick();
        tick();
        bus.i_nfu1_valid = 1'b0;
        wait_done("s3_done_seen");
        check("s3_ready_cnt", 32'(ready_cnt), 32'd5);
        check("s3_gate_cnt", 32'(gate_cnt), 32'd3);
        check("s3_wr_data", wr_data_log[0], 32'd21);
        check("s3_latency", done_cyc - start_cyc, 32'd11);

        // N_in=0 with NBout prime: value passes through unchanged.
        preload(8'd0, 32'd9);
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd0, 8'd1, 1'b1);
        wait_done("s4_done_seen");
        bus.i_nfu1_valid = 1'b0;
        check("s4_ready_cnt", 32'(ready_cnt), 32'd0);
        check("s4_gate_cnt", 32'(gate_cnt), 32'd0);
        check("s4_rd_cnt", 32'(rd_cnt), 32'd1);
        check("s4_wr_cnt", 32'(wr_cnt), 32'd1);
        check("s4_wr_data", wr_data_log[0], 32'd9);
        check("s4_latency", done_cyc - start_cyc, 32'd6);

        // N_out=0: done right after start, no NBout traffic.
        clear_mon();
        run_start(8'd3, 8'd0, 1'b1);
        wait_done("s5_done_seen");
        check("s5_latency", done_cyc - start_cyc, 32'd1);
        check("s5_rd_cnt", 32'(rd_cnt), 32'd0);
        check("s5_wr_cnt", 32'(wr_cnt), 32'd0);
        check("s5_busy_cycles", 32'(busy_cnt), 32'd0);

        // Reset during ACCUM after the first of four products.
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd4, 8'd1, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("s6_outs_after_rst", 32'(outs), 32'd0);
        rst = 1'b0;
        bus.i_nfu1_valid = 1'b0;
        repeat (12) tick();
        check("s6_no_write", 32'(wr_cnt), 32'd0);
        check("s6_no_done", 32'(done_cnt), 32'd0);
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd2, 8'd1, 1'b0);
        wait_done("s6_fresh_done_seen");
        bus.i_nfu1_valid = 1'b0;
        check("s6_fresh_wr_data", wr_data_log[0], 32'd10);
        check("s6_fresh_latency", done_cyc - start_cyc, 32'd8);

        // Start re-pulse and config change mid-pass are ignored.
        clear_mon();
        bus.i_nfu1_valid = 1'b1;
        run_start(8'd2, 8'd2, 1'b0);
        tick();
        tick();
        bus.i_num_in_tiles  = 8'd5;
        bus.i_num_out_tiles = 8'd7;
        bus.i_acc_init      = 1'b1;
        bus.i_start         = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done("s7_done_seen");
        bus.i_nfu1_valid = 1'b0;
        check("s7_gate_cnt", 32'(gate_cnt), 32'd4);
        check("s7_rd_cnt", 32'(rd_cnt), 32'd0);
        check("s7_wr_cnt", 32'(wr_cnt), 32'd2);
        check("s7_wr_addr1", 32'(wr_addr_log[1]), 32'd1);
        check("s7_wr_data0", wr_data_log[0], 32'd10);
        check("s7_wr_data1", wr_data_log[1], 32'd26);
        check("s7_latency", done_cyc - start_cyc, 32'd15);
        check("s7_load_gate_overlap", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
